// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: funct3 access types, FSM states
// and small decode helpers used by the top and the load-extension block.
package load_store_unit_pkg;

  localparam logic [2:0] LOAD_LB  = 3'b000;
  localparam logic [2:0] LOAD_LH  = 3'b001;
  localparam logic [2:0] LOAD_LW  = 3'b010;
  localparam logic [2:0] LOAD_LBU = 3'b100;
  localparam logic [2:0] LOAD_LHU = 3'b101;
  localparam logic [2:0] STORE_SB = 3'b000;
  localparam logic [2:0] STORE_SH = 3'b001;
  localparam logic [2:0] STORE_SW = 3'b010;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SPLIT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {OP_NONE, OP_LOAD, OP_STORE} lsu_op_e;

  function automatic logic [2:0] access_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   access_size = 3'd1;
      2'b01:   access_size = 3'd2;
      default: access_size = 3'd4;
    endcase
  endfunction

  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    if (is_store) begin
      f3_legal = (f3 == STORE_SB) || (f3 == STORE_SH) || (f3 == STORE_SW);
    end else begin
      f3_legal = (f3 == LOAD_LB) || (f3 == LOAD_LH) || (f3 == LOAD_LW) ||
                 (f3 == LOAD_LBU) || (f3 == LOAD_LHU);
    end
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and the memory (slave).
interface load_store_unit_if #(parameter int ADDR_W = 6);
  logic              dm_MemRead;
  logic              dm_MemWrite;
  logic [2:0]        dm_F3;
  logic [ADDR_W-1:0] dm_addr;
  logic [31:0]       dm_data_in;
  logic [31:0]       dm_data_out;

  modport master (output dm_MemRead, dm_MemWrite, dm_F3, dm_addr, dm_data_in,
                  input  dm_data_out);
  modport slave  (input  dm_MemRead, dm_MemWrite, dm_F3, dm_addr, dm_data_in,
                  output dm_data_out);
endinterface

// File: rtl/load_store_unit_load_extend.sv
// Sign/zero extension of a raw little-endian load word according to funct3.
module lsu_load_extend
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] raw,
  output logic [31:0] result
);

  // select extension by access type
  always_comb begin
    result = 32'd0;
    case (funct3)
      LOAD_LB:  result = {{24{raw[7]}}, raw[7:0]};
      LOAD_LH:  result = {{16{raw[15]}}, raw[15:0]};
      LOAD_LW:  result = raw;
      LOAD_LBU: result = {24'd0, raw[7:0]};
      LOAD_LHU: result = {16'd0, raw[15:0]};
      default:  result = 32'd0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: aligned accesses pass straight through, misaligned
// ones are split into byte accesses while the pipeline is stalled.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mem_read,
  input  logic                      mem_write,
  input  logic [2:0]                funct3,
  input  logic [31:0]               addr,
  input  logic [31:0]               wdata,
  output logic [31:0]               load_data,
  output logic                      stall,
  output logic                      access_fault,
  load_store_unit_if.master         dm
);

  logic [1:0]        state_r;
  logic [1:0]        cnt_r;
  logic [31:0]       buf_r;
  lsu_op_e           op_s;
  logic              is_load_s;
  logic [2:0]        size_s;
  logic [32:0]       end_addr_s;
  logic              misaligned_s;
  logic              fault_s;
  logic              issue_s;
  logic [31:0]       ext_raw_s;
  logic [31:0]       ext_result_s;
  logic              dm_rd_s;
  logic              dm_wr_s;
  logic [2:0]        dm_f3_s;
  logic [ADDR_W-1:0] dm_addr_s;
  logic [31:0]       dm_din_s;
  logic              stall_s;
  logic [31:0]       load_data_s;

  // request decode; a simultaneous read and write is a store
  always_comb begin
    if (mem_write) begin
      op_s = OP_STORE;
    end else if (mem_read) begin
      op_s = OP_LOAD;
    end else begin
      op_s = OP_NONE;
    end
  end

  assign is_load_s    = (op_s == OP_LOAD);
  assign size_s       = access_size(funct3);
  assign end_addr_s   = {1'b0, addr} + {30'd0, size_s} - 33'd1;
  assign misaligned_s = ((size_s == 3'd2) && addr[0]) ||
                        ((size_s == 3'd4) && (addr[1:0] != 2'b00));
  // faults are only judged on a fresh request, never mid-split
  assign fault_s      = rst && (state_r == ST_IDLE) && (op_s != OP_NONE) &&
                        (!f3_legal(op_s == OP_STORE, funct3) ||
                         ((end_addr_s >> ADDR_W) != 33'd0));
  assign issue_s      = (op_s != OP_NONE) && !fault_s;

  assign ext_raw_s = (state_r == ST_DONE) ? buf_r : dm.dm_data_out;

  lsu_load_extend u_extend (
    .funct3 (funct3),
    .raw    (ext_raw_s),
    .result (ext_result_s)
  );

  // split sequencing: byte counter and load reassembly buffer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= 2'd0;
      buf_r   <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (issue_s && misaligned_s) begin
            state_r <= ST_SPLIT;
            cnt_r   <= 2'd1;
            buf_r   <= is_load_s ? {24'd0, dm.dm_data_out[7:0]} : 32'd0;
          end
        end
        ST_SPLIT: begin
          if (is_load_s) begin
            buf_r[{cnt_r, 3'b000} +: 8] <= dm.dm_data_out[7:0];
          end
          cnt_r <= cnt_r + 2'd1;
          if ({1'b0, cnt_r} == (size_s - 3'd1)) begin
            state_r <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          cnt_r   <= 2'd0;
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= 2'd0;
        end
      endcase
    end
  end

  // memory strobes, stall and load result; everything quiet while in reset
  always_comb begin
    dm_rd_s     = 1'b0;
    dm_wr_s     = 1'b0;
    dm_f3_s     = funct3;
    dm_addr_s   = addr[ADDR_W-1:0];
    dm_din_s    = wdata;
    stall_s     = 1'b0;
    load_data_s = 32'd0;
    if (!rst) begin
      stall_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (issue_s && misaligned_s) begin
            dm_rd_s = is_load_s;
            dm_wr_s = !is_load_s;
            dm_f3_s = is_load_s ? LOAD_LBU : STORE_SB;
            stall_s = 1'b1;
          end else if (issue_s) begin
            dm_rd_s     = is_load_s;
            dm_wr_s     = !is_load_s;
            load_data_s = is_load_s ? ext_result_s : 32'd0;
          end else begin
            stall_s = 1'b0;
          end
        end
        ST_SPLIT: begin
          dm_rd_s   = is_load_s;
          dm_wr_s   = !is_load_s;
          dm_f3_s   = is_load_s ? LOAD_LBU : STORE_SB;
          dm_addr_s = addr[ADDR_W-1:0] + ADDR_W'(cnt_r);
          dm_din_s  = wdata >> {cnt_r, 3'b000};
          stall_s   = 1'b1;
        end
        ST_DONE: begin
          load_data_s = is_load_s ? ext_result_s : 32'd0;
        end
        default: begin
          stall_s = 1'b0;
        end
      endcase
    end
  end

  assign dm.dm_MemRead  = dm_rd_s;
  assign dm.dm_MemWrite = dm_wr_s;
  assign dm.dm_F3       = dm_f3_s;
  assign dm.dm_addr     = dm_addr_s;
  assign dm.dm_data_in  = dm_din_s;
  assign stall          = stall_s;
  assign load_data      = load_data_s;
  assign access_fault   = fault_s;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a 64-byte memory model.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] load_data;
  logic        stall;
  logic        access_fault;
  logic        preload_req;
  logic [7:0]  mem [0:63];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  load_store_unit_if #(.ADDR_W(6)) dm_bus ();

  load_store_unit #(.ADDR_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .funct3       (funct3),
    .addr         (addr),
    .wdata        (wdata),
    .load_data    (load_data),
    .stall        (stall),
    .access_fault (access_fault),
    .dm           (dm_bus)
  );

  // memory model: combinational little-endian read, byte/half/word write
  assign dm_bus.dm_data_out = {mem[dm_bus.dm_addr + 6'd3], mem[dm_bus.dm_addr + 6'd2],
                               mem[dm_bus.dm_addr + 6'd1], mem[dm_bus.dm_addr]};

  always @(posedge clk) begin
    if (preload_req) begin
      for (int i = 0; i < 64; i++) mem[i] <= 8'd0;
      mem[0] <= 8'd17;
      mem[4] <= 8'd9;
      mem[8] <= 8'd25;
    end else if (dm_bus.dm_MemWrite) begin
      case (dm_bus.dm_F3[1:0])
        2'b00: mem[dm_bus.dm_addr] <= dm_bus.dm_data_in[7:0];
        2'b01: begin
          mem[dm_bus.dm_addr]        <= dm_bus.dm_data_in[7:0];
          mem[dm_bus.dm_addr + 6'd1] <= dm_bus.dm_data_in[15:8];
        end
        default: begin
          mem[dm_bus.dm_addr]        <= dm_bus.dm_data_in[7:0];
          mem[dm_bus.dm_addr + 6'd1] <= dm_bus.dm_data_in[15:8];
          mem[dm_bus.dm_addr + 6'd2] <= dm_bus.dm_data_in[23:16];
          mem[dm_bus.dm_addr + 6'd3] <= dm_bus.dm_data_in[31:24];
        end
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    mem_read  = rd;
    mem_write = wr;
    funct3    = f3;
    addr      = a;
    wdata     = wd;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, LOAD_LW, 32'd5, 32'd0);
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || access_fault !== 1'b0 || load_data !== 32'd0 ||
        dm_bus.dm_MemRead !== 1'b0 || dm_bus.dm_MemWrite !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got stall=%b fault=%b ld=%h rd=%b wr=%b expected all zero",
               stall, access_fault, load_data, dm_bus.dm_MemRead, dm_bus.dm_MemWrite);
    end
    drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    tick();
    rst = 1'b1;
  endtask

  task automatic test_aligned_load();
    drive(1'b1, 1'b0, LOAD_LW, 32'd4, 32'd0);
    @(negedge clk);
    checks++;
    if (load_data !== 32'd9 || stall !== 1'b0 || dm_bus.dm_MemRead !== 1'b1) begin
      errors++;
      $display("FAIL lw_aligned: got ld=%h stall=%b rd=%b expected ld=00000009 stall=0 rd=1",
               load_data, stall, dm_bus.dm_MemRead);
    end
    tick();
    drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    @(negedge clk);
    checks++;
    if (load_data !== 32'd0 || dm_bus.dm_MemRead !== 1'b0) begin
      errors++;
      $display("FAIL idle_quiet: got ld=%h rd=%b expected ld=00000000 rd=0",
               load_data, dm_bus.dm_MemRead);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [2:0] f3s [2];
    f3s[0] = LOAD_LH;
    f3s[1] = LOAD_LHU;
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b0, f3s[k], 32'd3, 32'd0);
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        checks++;
        if (stall !== (c < 2)) begin
          errors++;
          $display("FAIL half_stall k%0d c%0d: got %b expected %b", k, c, stall, (c < 2));
        end
        if (c < 2) begin
          checks++;
          if (dm_bus.dm_MemRead !== 1'b1 || dm_bus.dm_F3 !== LOAD_LBU ||
              dm_bus.dm_addr !== 6'(3 + c)) begin
            errors++;
            $display("FAIL half_issue k%0d c%0d: got rd=%b f3=%b a=%0d expected rd=1 f3=100 a=%0d",
                     k, c, dm_bus.dm_MemRead, dm_bus.dm_F3, dm_bus.dm_addr, 3 + c);
          end
        end else begin
          checks++;
          if (load_data !== 32'h0000_0900 || dm_bus.dm_MemRead !== 1'b0) begin
            errors++;
            $display("FAIL half_done k%0d: got ld=%h rd=%b expected ld=00000900 rd=0",
                     k, load_data, dm_bus.dm_MemRead);
          end
        end
        tick();
      end
    end
    drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    tick();
  endtask

  task automatic test_misaligned_word();
    logic [31:0] w;
    w = 32'hAABB_CCDD;
    drive(1'b0, 1'b1, STORE_SW, 32'd5, w);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (c < 4) begin
        if (stall !== 1'b1 || dm_bus.dm_MemWrite !== 1'b1 || dm_bus.dm_addr !== 6'(5 + c) ||
            dm_bus.dm_data_in[7:0] !== w[8*c +: 8] || dm_bus.dm_F3 !== STORE_SB) begin
          errors++;
          $display("FAIL sw_split c%0d: got stall=%b wr=%b a=%0d d=%h expected 1 1 %0d %h",
                   c, stall, dm_bus.dm_MemWrite, dm_bus.dm_addr, dm_bus.dm_data_in[7:0],
                   5 + c, w[8*c +: 8]);
        end
      end else begin
        if (stall !== 1'b0 || dm_bus.dm_MemWrite !== 1'b0) begin
          errors++;
          $display("FAIL sw_done: got stall=%b wr=%b expected 0 0", stall, dm_bus.dm_MemWrite);
        end
      end
      tick();
    end
    checks++;
    if ({mem[8], mem[7], mem[6], mem[5]} !== w) begin
      errors++;
      $display("FAIL sw_mem: got %h expected %h", {mem[8], mem[7], mem[6], mem[5]}, w);
    end
    drive(1'b1, 1'b0, LOAD_LW, 32'd5, 32'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (stall !== (c < 4)) begin
        errors++;
        $display("FAIL lw_split_stall c%0d: got %b expected %b", c, stall, (c < 4));
      end
      if (c == 4) begin
        checks++;
        if (load_data !== w) begin
          errors++;
          $display("FAIL lw_split_data: got %h expected %h", load_data, w);
        end
      end
      tick();
    end
    drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    tick();
  endtask

  task automatic test_byte();
    drive(1'b0, 1'b1, STORE_SB, 32'd12, 32'h0000_0080);
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || dm_bus.dm_MemWrite !== 1'b1) begin
      errors++;
      $display("FAIL sb: got stall=%b wr=%b expected 0 1", stall, dm_bus.dm_MemWrite);
    end
    tick();
    drive(1'b1, 1'b0, LOAD_LB, 32'd12, 32'd0);
    @(negedge clk);
    checks++;
    if (load_data !== 32'hFFFF_FF80) begin
      errors++;
      $display("FAIL lb: got %h expected ffffff80", load_data);
    end
    tick();
    drive(1'b1, 1'b0, LOAD_LBU, 32'd12, 32'd0);
    @(negedge clk);
    checks++;
    if (load_data !== 32'h0000_0080) begin
      errors++;
      $display("FAIL lbu: got %h expected 00000080", load_data);
    end
    tick();
    drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    tick();
  endtask

  task automatic test_fault();
    logic [2:0]  f3s [5];
    logic [31:0] as  [5];
    logic        wrs [5];
    logic        exp [5];
    f3s[0] = LOAD_LW;  as[0] = 32'd62; wrs[0] = 1'b0; exp[0] = 1'b1;
    f3s[1] = 3'b011;   as[1] = 32'd0;  wrs[1] = 1'b0; exp[1] = 1'b1;
    f3s[2] = STORE_SW; as[2] = 32'd62; wrs[2] = 1'b1; exp[2] = 1'b1;
    f3s[3] = 3'b100;   as[3] = 32'd20; wrs[3] = 1'b1; exp[3] = 1'b1;
    f3s[4] = LOAD_LH;  as[4] = 32'd62; wrs[4] = 1'b0; exp[4] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(!wrs[k], wrs[k], f3s[k], as[k], 32'hDEAD_BEEF);
      @(negedge clk);
      checks++;
      if (access_fault !== exp[k] || stall !== 1'b0 ||
          (exp[k] && (dm_bus.dm_MemRead !== 1'b0 || dm_bus.dm_MemWrite !== 1'b0))) begin
        errors++;
        $display("FAIL fault k%0d: got fault=%b stall=%b rd=%b wr=%b expected fault=%b stall=0",
                 k, access_fault, stall, dm_bus.dm_MemRead, dm_bus.dm_MemWrite, exp[k]);
      end
      tick();
    end
    drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    tick();
    checks++;
    if (mem[62] !== 8'd0 || mem[63] !== 8'd0 || mem[20] !== 8'd0 || mem[0] !== 8'd17) begin
      errors++;
      $display("FAIL fault_mem: got m62=%h m63=%h m20=%h m0=%h expected 00 00 00 11",
               mem[62], mem[63], mem[20], mem[0]);
    end
  endtask

  task automatic test_reset_mid_split();
    drive(1'b0, 1'b1, STORE_SW, 32'd9, 32'h1122_3344);
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0 || dm_bus.dm_MemWrite !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: got stall=%b wr=%b expected 0 0", stall, dm_bus.dm_MemWrite);
    end
    tick();
    tick();
    drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    checks++;
    if (mem[9] !== 8'h44 || mem[10] !== 8'h33 || mem[11] !== 8'h00 || mem[12] !== 8'h80) begin
      errors++;
      $display("FAIL rst_mem: got %h %h %h %h expected 44 33 00 80",
               mem[9], mem[10], mem[11], mem[12]);
    end
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    rst         = 1'b0;
    preload_req = 1'b1;
    drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    tick();
    tick();
    preload_req = 1'b0;
    test_reset();
    test_aligned_load();
    test_back_to_back();
    test_misaligned_word();
    test_byte();
    test_fault();
    test_reset_mid_split();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 6: data-memory byte-address width (64-byte space).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port mem_read  input  1  MEM-stage load request.
REQ-005 SHALL have port mem_write  input  1  MEM-stage store request; mem_read and mem_write both high is treated as a store.
REQ-006 SHALL have port funct3  input  3  access type (LB/LH/LW/LBU/LHU, SB/SH/SW encodings).
REQ-007 SHALL have port addr  input  32  byte address from the ALU.
REQ-008 SHALL have port wdata  input  32  store data (rs2).
REQ-009 SHALL have port load_data  output  32  sign- or zero-extended load result.
REQ-010 SHALL have port stall  output  1  freezes the pipeline; inputs stay stable while high.
REQ-011 SHALL have port access_fault  output  1  out-of-range or illegal-funct3 request; no memory access is made.
REQ-012 SHALL have ports dm_MemRead, dm_MemWrite  output  1 each  data-memory strobes.
REQ-013 SHALL have port dm_F3  output  3  data-memory access type.
REQ-014 SHALL have port dm_addr  output  ADDR_W  data-memory byte address.
REQ-015 SHALL have port dm_data_in  output  32  data-memory write data.
REQ-016 SHALL have port dm_data_out  input  32  data-memory combinational read data.

Function
REQ-017 SHALL define size = 1/2/4 bytes; misaligned = half with addr[0]=1, or word with addr[1:0]!=0.
REQ-018 SHALL assert access_fault combinationally, with no dm strobes and stall=0, when addr+size-1 > 2^ADDR_W-1 or funct3 is not a legal encoding for the operation.
REQ-019 Aligned requests SHALL pass straight through in a single cycle: dm strobes/F3/addr/data_in driven from inputs, load_data = dm_data_out, stall=0.
REQ-020 Misaligned requests SHALL use FSM states IDLE, SPLIT, DONE.
REQ-021 IDLE, misaligned request: issue byte 0 (LBU or SB at addr), stall=1, byte counter=1, go to SPLIT.
REQ-022 SPLIT: issue byte cnt at addr+cnt, stall=1; cnt increments; after byte size-1 go to DONE.
REQ-023 Byte i of a split store SHALL be wdata[8i+7:8i]; byte i of a split load SHALL be captured into buffer byte i.
REQ-024 DONE: no dm strobes, stall=0, load_data = buffer extended per funct3 (LH sign from bit 15, LHU zero), then return to IDLE.
REQ-025 Latency SHALL be 3 cycles for a misaligned half and 5 for a misaligned word, with stall high for all but the last.
REQ-026 Outside an active load, load_data SHALL be 0; dm strobes SHALL be 0 whenever no access is issued.

Reset
REQ-027 rst low SHALL immediately force: state IDLE, counter 0, buffer 0, stall 0, load_data 0, access_fault 0, dm strobes 0.
REQ-028 Reset mid-split SHALL abandon the access; bytes already stored remain written, and no further bytes are written.

Structure
REQ-029 funct3 encodings (LOAD_*, STORE_*) SHALL come from the shared defines.v; FSM state encodings SHALL be added there.
REQ-030 Load extension SHALL be a sub-module lsu_load_extend (funct3 + 32-bit raw -> 32-bit result), shared by the aligned and DONE paths.

Verification
REQ-031 Memory preloaded with 17/9/25 at 0/4/8; LW addr 4 -> load_data=9, stall=0, single cycle.
REQ-032 LH addr 3 -> stall high 2 cycles, DONE cycle load_data=0x00000900; LHU addr 3 gives the same.
REQ-033 SW 0xAABBCCDD addr 5 -> 4 byte writes over 4 stalled cycles; then LW addr 5 -> 0xAABBCCDD (5 cycles).
REQ-034 SB 0x80 addr 12, then LB addr 12 -> 0xFFFFFF80; LBU addr 12 -> 0x00000080.
REQ-035 LW addr 62, and funct3=3'b011 load -> access_fault=1, dm strobes 0, memory unchanged.
REQ-036 SW 0x11223344 addr 9, rst low after 2 byte writes -> mem[9]=0x44, mem[10]=0x33, mem[11,12] unchanged, stall=0.
